// File: rtl/uart_apb_ctrl.sv
// ---------------------------------------------------------------------------
// uart_apb_ctrl
//
// APB front end of the UART. It turns APB transfers into TX FIFO pushes,
// RX FIFO pops and control register updates. It inserts wait states while
// the TX FIFO is full and for the one-cycle RX FIFO read latency.
//
// Register map (byte addresses):
//   0x0 TXDATA  write-only, pushes PWDATA[DATA_WIDTH-1:0] into the TX FIFO
//   0x4 RXDATA  read-only, pops one character from the RX FIFO
//   0x8 STATUS  read-only, returns status_in
//   0xC CTRL    read/write: [31:16] baud_div, [1] rx_enable, [0] tx_enable
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   PSEL, PENABLE, PWRITE APB control
//   PADDR, PWDATA         APB address and write data
//   PRDATA, PREADY,       APB read data, completion and error response
//   PSLVERR
//   tx_wr_data, wr_en_tx  TX FIFO write data and push strobe
//   wr_full_tx            TX FIFO full flag
//   rd_en_rx              RX FIFO pop strobe
//   rx_rd_data            RX FIFO data, valid the cycle after rd_en_rx
//   rd_empty_rx           RX FIFO empty flag
//   status_in             status word from the UART status register block
//   tx_enable, rx_enable, control register fields
//   baud_div
// ---------------------------------------------------------------------------
module uart_apb_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int TIMEOUT      = 16,
    parameter int BAUD_DIV_RST = 27
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [3:0]            PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] tx_wr_data,
    output logic                  wr_en_tx,
    input  logic                  wr_full_tx,
    output logic                  rd_en_rx,
    input  logic [DATA_WIDTH-1:0] rx_rd_data,
    input  logic                  rd_empty_rx,
    input  logic [31:0]           status_in,
    output logic                  tx_enable,
    output logic                  rx_enable,
    output logic [15:0]           baud_div
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_WAIT = 2'd1,
        RX_POP  = 2'd2
    } state_e;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic             txEnable_q, txEnable_d;
    logic             rxEnable_q, rxEnable_d;
    logic [15:0]      baudDiv_q, baudDiv_d;

    logic             accessCycle;
    logic             addrMisaligned;
    logic [1:0]       regSel;
    logic [31:0]      ctrlWord;
    logic             unusedPwdata;

    assign accessCycle    = PSEL & PENABLE;
    assign addrMisaligned = (PADDR[1:0] != 2'b00);
    assign regSel         = PADDR[3:2];
    assign ctrlWord       = {baudDiv_q, 14'd0, rxEnable_q, txEnable_q};
    assign unusedPwdata   = ^PWDATA[15:2];

    assign tx_enable = txEnable_q;
    assign rx_enable = rxEnable_q;
    assign baud_div  = baudDiv_q;

    // State, wait counter and CTRL fields. Reset wins over any transfer
    // that happens to be in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            txEnable_q <= 1'b0;
            rxEnable_q <= 1'b0;
            baudDiv_q  <= 16'(BAUD_DIV_RST);
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            txEnable_q <= txEnable_d;
            rxEnable_q <= rxEnable_d;
            baudDiv_q  <= baudDiv_d;
        end
    end

    // Transfer decode, next state and all APB/FIFO outputs. Everything is
    // held at zero while reset is asserted so no strobe escapes during the
    // reset cycle itself.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        txEnable_d = txEnable_q;
        rxEnable_d = rxEnable_q;
        baudDiv_d  = baudDiv_q;
        PRDATA     = 32'd0;
        PREADY     = 1'b0;
        PSLVERR    = 1'b0;
        tx_wr_data = '0;
        wr_en_tx   = 1'b0;
        rd_en_rx   = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (accessCycle) begin
                        if (addrMisaligned) begin
                            PREADY  = 1'b1;
                            PSLVERR = 1'b1;
                        end else begin
                            case (regSel)
                                REG_TXDATA: begin
                                    if (!PWRITE || !txEnable_q) begin
                                        PREADY  = 1'b1;
                                        PSLVERR = 1'b1;
                                    end else if (!wr_full_tx) begin
                                        wr_en_tx   = 1'b1;
                                        tx_wr_data = PWDATA[DATA_WIDTH-1:0];
                                        PREADY     = 1'b1;
                                    end else begin
                                        state_d   = TX_WAIT;
                                        waitCnt_d = '0;
                                    end
                                end
                                REG_RXDATA: begin
                                    if (PWRITE || rd_empty_rx) begin
                                        PREADY  = 1'b1;
                                        PSLVERR = 1'b1;
                                    end else begin
                                        // Data arrives next cycle; complete in RX_POP.
                                        rd_en_rx = 1'b1;
                                        state_d  = RX_POP;
                                    end
                                end
                                REG_STATUS: begin
                                    PREADY = 1'b1;
                                    if (PWRITE) begin
                                        PSLVERR = 1'b1;
                                    end else begin
                                        PRDATA = status_in;
                                    end
                                end
                                default: begin
                                    // CTRL: only [31:16] and [1:0] are storage.
                                    PREADY = 1'b1;
                                    if (PWRITE) begin
                                        baudDiv_d  = PWDATA[31:16];
                                        rxEnable_d = PWDATA[1];
                                        txEnable_d = PWDATA[0];
                                    end else begin
                                        PRDATA = ctrlWord;
                                    end
                                end
                            endcase
                        end
                    end
                end

                TX_WAIT: begin
                    waitCnt_d = waitCnt_q + 1'b1;
                    if (!PSEL) begin
                        // Master abandoned the transfer: drop it silently.
                        state_d = IDLE;
                    end else if (!wr_full_tx) begin
                        wr_en_tx   = 1'b1;
                        tx_wr_data = PWDATA[DATA_WIDTH-1:0];
                        PREADY     = 1'b1;
                        state_d    = IDLE;
                    end else if (waitCnt_q == CNT_LAST) begin
                        PREADY  = 1'b1;
                        PSLVERR = 1'b1;
                        state_d = IDLE;
                    end
                end

                RX_POP: begin
                    // The popped byte is lost if PSEL has dropped.
                    state_d = IDLE;
                    if (PSEL) begin
                        PREADY = 1'b1;
                        PRDATA = 32'(rx_rd_data);
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_apb_ctrl
//
// Directed self-checking bench for uart_apb_ctrl. Inputs change 2 time units
// after each rising edge and outputs are sampled 1 unit later, well away
// from the next edge.
// ---------------------------------------------------------------------------
module tb_uart_apb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  txWrData;
    logic        wrEnTx, wrFullTx;
    logic        rdEnRx;
    logic [7:0]  rxRdData;
    logic        rdEmptyRx;
    logic [31:0] statusIn;
    logic        txEnable, rxEnable;
    logic [15:0] baudDiv;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    uart_apb_ctrl #(
        .DATA_WIDTH  (8),
        .TIMEOUT     (16),
        .BAUD_DIV_RST(27)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PSEL       (psel),
        .PENABLE    (penable),
        .PWRITE     (pwrite),
        .PADDR      (paddr),
        .PWDATA     (pwdata),
        .PRDATA     (prdata),
        .PREADY     (pready),
        .PSLVERR    (pslverr),
        .tx_wr_data (txWrData),
        .wr_en_tx   (wrEnTx),
        .wr_full_tx (wrFullTx),
        .rd_en_rx   (rdEnRx),
        .rx_rd_data (rxRdData),
        .rd_empty_rx(rdEmptyRx),
        .status_in  (statusIn),
        .tx_enable  (txEnable),
        .rx_enable  (rxEnable),
        .baud_div   (baudDiv)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                                 input logic [3:0] addr, input logic [31:0] data);
        psel    = sel;
        penable = en;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Setup phase (checked to be quiet) followed by the first access cycle;
    // returns at the sampling point of that access cycle.
    task automatic startTransfer(input string tag, input logic wr,
                                 input logic [3:0] addr, input logic [31:0] data);
        nextCycle();
        applyStimulus(1'b1, 1'b0, wr, addr, data);
        #1;
        checkOutput({tag, " setup PREADY"}, 32'(pready), 32'd0);
        checkOutput({tag, " setup wr_en_tx"}, 32'(wrEnTx), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, wr, addr, data);
        #1;
    endtask

    task automatic endTransfer();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'd0);
        #1;
    endtask

    task automatic checkErrorResponse(input string tag);
        checkOutput({tag, " PREADY"}, 32'(pready), 32'd1);
        checkOutput({tag, " PSLVERR"}, 32'(pslverr), 32'd1);
        checkOutput({tag, " PRDATA"}, prdata, 32'd0);
        checkOutput({tag, " strobes"}, {30'd0, wrEnTx, rdEnRx}, 32'd0);
    endtask

    task automatic readCtrl(input string tag, input logic [31:0] expected);
        startTransfer(tag, 1'b0, 4'hC, 32'd0);
        checkOutput({tag, " PREADY"}, 32'(pready), 32'd1);
        checkOutput({tag, " PSLVERR"}, 32'(pslverr), 32'd0);
        checkOutput({tag, " PRDATA"}, prdata, expected);
        endTransfer();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  waitStates;
        bit  sawPush;

        rst       = 1'b1;
        wrFullTx  = 1'b0;
        rxRdData  = 8'h00;
        rdEmptyRx = 1'b1;
        statusIn  = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'd0);

        // Reset state, including a live access cycle that must stay silent.
        repeat (2) nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hC, 32'd0);
        #1;
        checkOutput("reset PREADY", 32'(pready), 32'd0);
        checkOutput("reset PRDATA", prdata, 32'd0);
        checkOutput("reset tx_enable", 32'(txEnable), 32'd0);
        checkOutput("reset rx_enable", 32'(rxEnable), 32'd0);
        checkOutput("reset baud_div", 32'(baudDiv), 32'd27);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'd0);

        readCtrl("ctrl after reset", 32'h001B_0000);

        // TX write while the transmitter is disabled.
        startTransfer("tx disabled", 1'b1, 4'h0, 32'h0000_0077);
        checkErrorResponse("tx disabled");
        endTransfer();

        startTransfer("status", 1'b0, 4'h8, 32'd0);
        checkOutput("status PREADY", 32'(pready), 32'd1);
        checkOutput("status PRDATA", prdata, 32'hDEAD_BEEF);
        endTransfer();

        // CTRL write: takes effect on the completing edge.
        startTransfer("ctrl write", 1'b1, 4'hC, 32'h0010_0003);
        checkOutput("ctrl write PREADY", 32'(pready), 32'd1);
        checkOutput("ctrl write PSLVERR", 32'(pslverr), 32'd0);
        endTransfer();
        checkOutput("ctrl tx_enable", 32'(txEnable), 32'd1);
        checkOutput("ctrl rx_enable", 32'(rxEnable), 32'd1);
        checkOutput("ctrl baud_div", 32'(baudDiv), 32'd16);
        readCtrl("ctrl readback", 32'h0010_0003);

        // TX push with space: zero wait states, one-cycle strobe.
        startTransfer("tx push", 1'b1, 4'h0, 32'h1234_56A5);
        checkOutput("tx push wr_en_tx", 32'(wrEnTx), 32'd1);
        checkOutput("tx push data", 32'(txWrData), 32'h0000_00A5);
        checkOutput("tx push PREADY", 32'(pready), 32'd1);
        checkOutput("tx push PSLVERR", 32'(pslverr), 32'd0);
        endTransfer();
        checkOutput("tx push strobe drop", 32'(wrEnTx), 32'd0);

        // FIFO full for three access cycles, then space.
        wrFullTx = 1'b1;
        startTransfer("tx full3", 1'b1, 4'h0, 32'h0000_005A);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("tx full3 wait%0d PREADY", i), 32'(pready), 32'd0);
            checkOutput($sformatf("tx full3 wait%0d wr_en_tx", i), 32'(wrEnTx), 32'd0);
            nextCycle();
            if (i == 2) wrFullTx = 1'b0;
            #1;
        end
        checkOutput("tx full3 PREADY", 32'(pready), 32'd1);
        checkOutput("tx full3 wr_en_tx", 32'(wrEnTx), 32'd1);
        checkOutput("tx full3 data", 32'(txWrData), 32'h0000_005A);
        checkOutput("tx full3 PSLVERR", 32'(pslverr), 32'd0);
        endTransfer();

        // FIFO full throughout: timeout after 16 wait states.
        wrFullTx = 1'b1;
        startTransfer("tx timeout", 1'b1, 4'h0, 32'h0000_00C3);
        waitStates = 0;
        sawPush    = 1'b0;
        while (!pready && waitStates < 40) begin
            if (wrEnTx) sawPush = 1'b1;
            nextCycle();
            #1;
            waitStates++;
        end
        checkOutput("tx timeout wait states", 32'(waitStates), 32'd16);
        checkOutput("tx timeout no push while waiting", 32'(sawPush), 32'd0);
        checkOutput("tx timeout PSLVERR", 32'(pslverr), 32'd1);
        checkOutput("tx timeout wr_en_tx", 32'(wrEnTx), 32'd0);
        endTransfer();

        // Master abandons a stalled TX write.
        startTransfer("tx abort", 1'b1, 4'h0, 32'h0000_0011);
        checkOutput("tx abort stall PREADY", 32'(pready), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'd0);
        wrFullTx = 1'b0;
        #1;
        checkOutput("tx abort wr_en_tx", 32'(wrEnTx), 32'd0);
        checkOutput("tx abort PREADY", 32'(pready), 32'd0);
        startTransfer("tx after abort", 1'b1, 4'h0, 32'h0000_0022);
        checkOutput("tx after abort wr_en_tx", 32'(wrEnTx), 32'd1);
        checkOutput("tx after abort data", 32'(txWrData), 32'h0000_0022);
        endTransfer();

        // RX read: pop, one wait state, data next cycle.
        rdEmptyRx = 1'b0;
        rxRdData  = 8'hFF;
        startTransfer("rx read", 1'b0, 4'h4, 32'd0);
        checkOutput("rx read rd_en_rx", 32'(rdEnRx), 32'd1);
        checkOutput("rx read PREADY wait", 32'(pready), 32'd0);
        checkOutput("rx read no tx strobe", 32'(wrEnTx), 32'd0);
        nextCycle();
        rxRdData = 8'h3C;
        #1;
        checkOutput("rx read rd_en_rx drop", 32'(rdEnRx), 32'd0);
        checkOutput("rx read PREADY", 32'(pready), 32'd1);
        checkOutput("rx read PRDATA", prdata, 32'h0000_003C);
        checkOutput("rx read PSLVERR", 32'(pslverr), 32'd0);
        endTransfer();

        rdEmptyRx = 1'b1;
        startTransfer("rx empty", 1'b0, 4'h4, 32'd0);
        checkErrorResponse("rx empty");
        endTransfer();

        // Illegal accesses; none may touch CTRL or the FIFOs.
        rdEmptyRx = 1'b0;
        startTransfer("write status", 1'b1, 4'h8, 32'hFFFF_FFFF);
        checkErrorResponse("write status");
        endTransfer();
        startTransfer("write rxdata", 1'b1, 4'h4, 32'hFFFF_FFFF);
        checkErrorResponse("write rxdata");
        endTransfer();
        startTransfer("read txdata", 1'b0, 4'h0, 32'd0);
        checkErrorResponse("read txdata");
        endTransfer();
        startTransfer("read 0x6", 1'b0, 4'h6, 32'd0);
        checkErrorResponse("read 0x6");
        endTransfer();
        startTransfer("write 0xE", 1'b1, 4'hE, 32'hFFFF_FFFF);
        checkErrorResponse("write 0xE");
        endTransfer();
        readCtrl("ctrl after errors", 32'h0010_0003);

        // Reset while stalled in TX_WAIT.
        wrFullTx = 1'b1;
        startTransfer("rst in wait", 1'b1, 4'h0, 32'h0000_0033);
        nextCycle();
        #1;
        checkOutput("rst in wait stalled PREADY", 32'(pready), 32'd0);
        nextCycle();
        rst      = 1'b1;
        wrFullTx = 1'b0;
        #1;
        checkOutput("rst in wait wr_en_tx", 32'(wrEnTx), 32'd0);
        checkOutput("rst in wait PREADY", 32'(pready), 32'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'd0);
        #1;
        checkOutput("rst in wait tx_enable", 32'(txEnable), 32'd0);
        checkOutput("rst in wait rx_enable", 32'(rxEnable), 32'd0);
        checkOutput("rst in wait baud_div", 32'(baudDiv), 32'd27);
        readCtrl("ctrl after rst in wait", 32'h001B_0000);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/uart_apb_ctrl.md
# uart_apb_ctrl

APB-side control and data-path front end of the UART peripheral: decodes APB read/write transfers and converts them into TX FIFO pushes, RX FIFO pops, and control-register updates. It complements the UART status register block: that block only publishes status bits, and this block is the write/transfer side that acts on them. It also inserts APB wait states for back-pressure and read latency. It sits between the SoC APB bridge and the UART TX/RX FIFOs.

## Interface
- DATA_WIDTH, 8, UART character width.
- TIMEOUT, 16, maximum wait cycles on a full TX FIFO before error completion (≥1).
- BAUD_DIV_RST, 27, reset value of the baud divisor field.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- PSEL, PENABLE, PWRITE  in  1 each  APB controls.
- PADDR  in  4  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid only with PREADY.
- tx_wr_data  out  DATA_WIDTH  TX FIFO write data.
- wr_en_tx  out  1  TX FIFO push strobe.
- wr_full_tx  in  1  TX FIFO full.
- rd_en_rx  out  1  RX FIFO pop strobe.
- rx_rd_data  in  DATA_WIDTH  RX FIFO data, valid one cycle after rd_en_rx.
- rd_empty_rx  in  1  RX FIFO empty.
- status_in  in  32  status word from the UART status register block.
- tx_enable, rx_enable  out  1 each  CTRL[0], CTRL[1].
- baud_div  out  16  CTRL[31:16].

## Operation
- Register map: 0x0 TXDATA (write-only), 0x4 RXDATA (read-only), 0x8 STATUS (read-only, returns status_in), 0xC CTRL (read/write; bits [15:2] read 0).
- The FSM has three states: IDLE, TX_WAIT, RX_POP. An access cycle is `PSEL & PENABLE` observed in IDLE.
- **TXDATA write, IDLE**
  - If `tx_enable=0`: complete immediately with PREADY=1, PSLVERR=1, no push.
  - Else if `!wr_full_tx`: drive wr_en_tx=1 and tx_wr_data=PWDATA[DATA_WIDTH-1:0] with PREADY=1 in the same cycle.
  - Else: go to TX_WAIT, clear the wait counter, and drive PREADY=0.
- **TX_WAIT**
  - Each cycle, wait counter increments.
  - If `!wr_full_tx`: push as above, PREADY=1, go to IDLE.
  - Else if counter == TIMEOUT-1: PREADY=1, PSLVERR=1, no push, go to IDLE.
- **RXDATA read, IDLE**
  - If `rd_empty_rx`: complete immediately with PREADY=1, PSLVERR=1, PRDATA=0.
  - Else: drive rd_en_rx=1 for exactly 1 cycle, PREADY=0, go to RX_POP.
- **RX_POP**: PRDATA={zero-extend rx_rd_data}, PREADY=1, go to IDLE.
- **STATUS/CTRL read**: zero wait states; PRDATA is driven combinationally in the access cycle.
- **CTRL write**: zero wait states; CTRL is updated on the completing edge from PWDATA[31:16] and PWDATA[1:0].
- **Error responses** (PREADY=1, PSLVERR=1, no side effect, PRDATA=0):
  - write to 0x4 or 0x8;
  - read of 0x0;
  - PADDR[1:0] != 0.
- **PSEL deassert during TX_WAIT or RX_POP**: return to IDLE with no push and no further pop. A popped RX byte is lost; this is accepted protocol-violation behaviour.
- PREADY, PSLVERR, PRDATA, wr_en_tx, rd_en_rx and tx_wr_data are combinational from state and inputs. Outside an access cycle they are driven to 0.
- wr_en_tx and rd_en_rx are never asserted together and never for more than 1 cycle per transfer.

## Timing
- Reset (synchronous, highest priority, overrides any in-flight transfer):
  - state = IDLE, wait counter = 0;
  - tx_enable = 0, rx_enable = 0, baud_div = BAUD_DIV_RST;
  - all strobes, PREADY, PSLVERR and PRDATA = 0.
- Latency in wait states:
  - TXDATA with space: 0;
  - TXDATA with a full FIFO: n, where n is the number of full cycles, up to TIMEOUT;
  - RXDATA: exactly 1;
  - STATUS and CTRL: 0.
- The full-to-not-full transition is sampled in the same cycle as the push; there is no extra cycle.
- Back-to-back transfers: a new setup phase may begin in the cycle after PREADY=1.

## Test plan
- After reset: read 0xC returns 0x001B0000, PSLVERR=0; write 0xC with 0x00100003 gives tx_enable=1, rx_enable=1, baud_div=16.
- tx_enable=1, FIFO not full, write 0x0 with 0xA5: wr_en_tx pulses 1 cycle with tx_wr_data=0xA5 and PREADY=1 in the first access cycle.
- wr_full_tx=1 for 3 access cycles then 0: PREADY low 3 cycles, then push and PREADY=1. With wr_full_tx held high, PREADY=1 and PSLVERR=1 after exactly 16 cycles, no push.
- RX FIFO holds 0x3C, read 0x4: rd_en_rx=1 for 1 cycle, next cycle PRDATA=0x3C and PREADY=1. With rd_empty_rx=1: immediate PSLVERR=1, no pop.
- Write 0x8, read 0x0, and access 0x6: each gives PSLVERR=1, CTRL unchanged, no strobes.
- rst asserted during TX_WAIT: next cycle state is IDLE, no push, CTRL returns to reset value.
